// File: rtl/result_collector.sv
// result_collector
//   Gathers binary pixels from NUM_PARALLEL worker lanes into one frame-buffer
//   write stream. Each lane has its own small FIFO of {row, col, data}. A
//   round-robin arbiter pops at most one FIFO per cycle, and the popped pixel is
//   registered onto the outputs. The block counts the emitted pixels and raises
//   a sticky frame-done flag once a full WIDTH*HEIGHT frame has been written.
//
// Ports
//   clock        rising-edge system clock
//   not_reset    asynchronous active-low reset
//   iResultCol   lane k column at [k*WIDTH_BITS +: WIDTH_BITS]
//   iResultRow   lane k row at [k*HEIGHT_BITS +: HEIGHT_BITS]
//   iResultData  lane k binary pixel
//   iResultWren  lane k write strobe (one pixel per high cycle; lanes are never stalled)
//   oX / oY      row / column of the emitted pixel
//   oR/oG/oB     {3{data}} of the emitted pixel
//   oWren        frame-buffer write strobe
//   oPixelCount  pixels emitted since reset (saturates at WIDTH*HEIGHT)
//   oFrameDone   sticky, high once a full frame has been emitted
//   oOverflow    sticky per-lane flag: a push was dropped on a full FIFO
module result_collector #(
  parameter int WIDTH_BITS        = 8,
  parameter int HEIGHT_BITS       = 8,
  parameter int NUM_PARALLEL_BITS = 2,
  parameter int FIFO_DEPTH_BITS   = 2
) (
  input  logic                                             clock,
  input  logic                                             not_reset,
  input  logic [(1 << NUM_PARALLEL_BITS)*WIDTH_BITS-1:0]  iResultCol,
  input  logic [(1 << NUM_PARALLEL_BITS)*HEIGHT_BITS-1:0] iResultRow,
  input  logic [(1 << NUM_PARALLEL_BITS)-1:0]             iResultData,
  input  logic [(1 << NUM_PARALLEL_BITS)-1:0]             iResultWren,
  output logic [HEIGHT_BITS-1:0]                          oX,
  output logic [WIDTH_BITS-1:0]                           oY,
  output logic [2:0]                                      oR,
  output logic [2:0]                                      oG,
  output logic [2:0]                                      oB,
  output logic                                            oWren,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]                 oPixelCount,
  output logic                                            oFrameDone,
  output logic [(1 << NUM_PARALLEL_BITS)-1:0]             oOverflow
);

  localparam int NP      = 1 << NUM_PARALLEL_BITS;
  localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int NPB     = NUM_PARALLEL_BITS;
  localparam int FDB     = FIFO_DEPTH_BITS;
  localparam int ENTRY_W = HEIGHT_BITS + WIDTH_BITS + 1;
  localparam int CNT_W   = WIDTH_BITS + HEIGHT_BITS + 1;

  localparam logic [CNT_W-1:0] FRAME_PIXELS = CNT_W'(1) << (WIDTH_BITS + HEIGHT_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [FDB:0]     PTR_ONE      = (FDB + 1)'(1);
  localparam logic [NPB-1:0]   RR_ONE       = NPB'(1);

  typedef enum logic {COLLECT, DONE} state_t;

  // FIFO entries are packed as {row, col, data}
  logic [ENTRY_W-1:0] fifoMem_q [NP][DEPTH];
  logic [FDB:0]       wrPtr_q   [NP];
  logic [FDB:0]       rdPtr_q   [NP];
  logic [FDB:0]       occupancy [NP];
  logic [NP-1:0]      fifoEmpty;
  logic [NP-1:0]      fifoFull;
  logic [NP-1:0]      popLane;
  logic [NP-1:0]      overflow_q;

  logic [NPB-1:0]     rrPtr_q, rrPtr_d;
  logic [NPB-1:0]     grantLane;
  logic [NPB-1:0]     candidate;
  logic               grantValid;
  logic [ENTRY_W-1:0] headEntry;

  logic [HEIGHT_BITS-1:0] outRow_q;
  logic [WIDTH_BITS-1:0]  outCol_q;
  logic                   outData_q;
  logic                   outWren_q;
  logic [CNT_W-1:0]       pixelCount_q, pixelCount_d;
  state_t                 state_q, state_d;

  // Pointers carry one extra wrap bit, so occupancy reaches DEPTH exactly when
  // the FIFO is full and its top bit alone identifies the full condition.
  always_comb begin
    fifoEmpty = '0;
    fifoFull  = '0;
    for (int k = 0; k < NP; k++) begin
      occupancy[k] = wrPtr_q[k] - rdPtr_q[k];
      fifoEmpty[k] = (occupancy[k] == '0);
      fifoFull[k]  = occupancy[k][FDB];
    end
  end

  // Round-robin search starting at rrPtr_q. Grants depend only on registered
  // occupancy, so a pixel pushed this cycle can be popped next cycle at the
  // earliest (no bypass path).
  always_comb begin
    grantValid = 1'b0;
    grantLane  = rrPtr_q;
    candidate  = rrPtr_q;
    for (int i = 0; i < NP; i++) begin
      candidate = rrPtr_q + NPB'(i);
      if (!grantValid && !fifoEmpty[candidate]) begin
        grantValid = 1'b1;
        grantLane  = candidate;
      end
    end
    popLane = '0;
    if (grantValid) begin
      popLane[grantLane] = 1'b1;
    end
    headEntry = fifoMem_q[grantLane][rdPtr_q[grantLane][FDB-1:0]];
    rrPtr_d   = grantValid ? (grantLane + RR_ONE) : rrPtr_q;
  end

  // Pixel counter saturates at a full frame; the state flips to DONE in the
  // same cycle the count reaches the frame size.
  always_comb begin
    pixelCount_d = pixelCount_q;
    state_d      = state_q;
    if (grantValid && (pixelCount_q != FRAME_PIXELS)) begin
      pixelCount_d = pixelCount_q + CNT_ONE;
    end
    case (state_q)
      COLLECT: if (pixelCount_d == FRAME_PIXELS) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = COLLECT;
    endcase
  end

  // A push into a full FIFO is still accepted when that lane is popped in the
  // same cycle: the write lands in the slot being freed.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      for (int k = 0; k < NP; k++) begin
        wrPtr_q[k] <= '0;
        rdPtr_q[k] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          fifoMem_q[k][d] <= '0;
        end
      end
      overflow_q <= '0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (iResultWren[k]) begin
          if (!fifoFull[k] || popLane[k]) begin
            fifoMem_q[k][wrPtr_q[k][FDB-1:0]] <= {iResultRow[k*HEIGHT_BITS +: HEIGHT_BITS],
                                                  iResultCol[k*WIDTH_BITS +: WIDTH_BITS],
                                                  iResultData[k]};
            wrPtr_q[k] <= wrPtr_q[k] + PTR_ONE;
          end else begin
            overflow_q[k] <= 1'b1;
          end
        end
        if (popLane[k]) begin
          rdPtr_q[k] <= rdPtr_q[k] + PTR_ONE;
        end
      end
    end
  end

  // Output registers: coordinates and colour only load on a grant, so they hold
  // their last value while oWren is low.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      rrPtr_q      <= '0;
      outRow_q     <= '0;
      outCol_q     <= '0;
      outData_q    <= 1'b0;
      outWren_q    <= 1'b0;
      pixelCount_q <= '0;
      state_q      <= COLLECT;
    end else begin
      rrPtr_q      <= rrPtr_d;
      outWren_q    <= grantValid;
      pixelCount_q <= pixelCount_d;
      state_q      <= state_d;
      if (grantValid) begin
        outRow_q  <= headEntry[ENTRY_W-1 -: HEIGHT_BITS];
        outCol_q  <= headEntry[WIDTH_BITS:1];
        outData_q <= headEntry[0];
      end
    end
  end

  assign oX          = outRow_q;
  assign oY          = outCol_q;
  assign oR          = {3{outData_q}};
  assign oG          = {3{outData_q}};
  assign oB          = {3{outData_q}};
  assign oWren       = outWren_q;
  assign oPixelCount = pixelCount_q;
  assign oFrameDone  = (state_q == DONE);
  assign oOverflow   = overflow_q;

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter WIDTH_BITS, default 8, column address width.
REQ-002 Parameter HEIGHT_BITS, default 8, row address width.
REQ-003 Parameter NUM_PARALLEL_BITS, default 2; NUM_PARALLEL = 2**NUM_PARALLEL_BITS worker lanes.
REQ-004 Parameter FIFO_DEPTH_BITS, default 2; per-lane FIFO depth = 2**FIFO_DEPTH_BITS entries.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low; ports are clock and not_reset.
REQ-006 clock  input  1  rising-edge system clock.
REQ-007 not_reset  input  1  asynchronous active-low reset.
REQ-008 iResultCol  input  NUM_PARALLEL*WIDTH_BITS  lane k column at bits [k*WIDTH_BITS +: WIDTH_BITS].
REQ-009 iResultRow  input  NUM_PARALLEL*HEIGHT_BITS  lane k row, same packing.
REQ-010 iResultData  input  NUM_PARALLEL  lane k binary pixel.
REQ-011 iResultWren  input  NUM_PARALLEL  lane k write strobe, one pixel per high cycle; no backpressure to lanes.
REQ-012 oX  output  HEIGHT_BITS  row of the emitted pixel.
REQ-013 oY  output  WIDTH_BITS  column of the emitted pixel.
REQ-014 oR, oG, oB  output  3 each  {3{data}} of the emitted pixel.
REQ-015 oWren  output  1  frame-buffer write strobe, one pixel per high cycle.
REQ-016 oPixelCount  output  WIDTH_BITS+HEIGHT_BITS+1  pixels emitted since reset.
REQ-017 oFrameDone  output  1  sticky, high once WIDTH*HEIGHT pixels emitted.
REQ-018 oOverflow  output  NUM_PARALLEL  sticky per-lane FIFO drop flag.

Function
REQ-019 Each lane SHALL have an independent FIFO of {row, col, data}, pushed on the cycle iResultWren[k] is high.
REQ-020 One pop per cycle total, granted by a round-robin arbiter over non-empty lanes.
REQ-021 Round-robin: priority pointer starts at lane 0; after a grant to lane k, the search starts at (k+1) mod NUM_PARALLEL; pointer unchanged when no lane is granted.
REQ-022 Outputs registered: pixel pushed at edge of cycle N SHALL appear with oWren=1 in cycle N+2 when uncontested (latency 2).
REQ-023 oWren low in every cycle with no grant in the previous cycle; oX/oY/oR/oG/oB hold their last values when oWren is low.
REQ-024 Per lane, FIFO order preserved: pixels leave in arrival order.
REQ-025 Push to a full FIFO with a pop of the same lane in the same cycle SHALL be accepted without loss.
REQ-026 Push to a full FIFO without a same-cycle pop SHALL be dropped, FIFO contents unchanged, oOverflow[k] set and held until reset.
REQ-027 Push and pop on an empty FIFO in the same cycle: no bypass; entry is popped on a later cycle.
REQ-028 FIFO pointers wrap modulo depth; full/empty distinguished by an extra pointer bit or an occupancy counter.
REQ-029 FSM states COLLECT, DONE; COLLECT -> DONE on the cycle oPixelCount becomes WIDTH*HEIGHT; DONE is terminal until reset.
REQ-030 oPixelCount increments by 1 per oWren cycle and saturates at WIDTH*HEIGHT; oFrameDone = (state == DONE).
REQ-031 In DONE, further lane writes are still buffered and emitted; count stays saturated.

Reset
REQ-032 not_reset low SHALL immediately clear all FIFOs, pointers and arbiter pointer to 0, oWren=0, oX=oY=0, oR=oG=oB=0, oPixelCount=0, oOverflow=0, state=COLLECT.
REQ-033 Reset mid-operation SHALL discard all buffered pixels; no oWren after release until a new lane write.

Verification
REQ-034 Single write lane 2 (row 5, col 9, data 1) at cycle N -> oWren=1 at N+2 only, oX=5, oY=9, oR=oG=oB=3'b111, oPixelCount=1.
REQ-035 All 4 lanes write once in the same cycle N -> oWren high N+2..N+5, lane order 0,1,2,3; next simultaneous burst after lane 3 grant starts at lane 0 again.
REQ-036 Lane 1 writes every cycle for 8 cycles while lanes 0,2,3 write every cycle (contention) -> oOverflow[1] set once its FIFO is full with no pop; emitted lane-1 pixels in order, no duplicates.
REQ-037 Lane 0 streams 65536 pixels at one per 4 cycles -> oFrameDone rises the cycle oPixelCount reaches 65536; extra write then emitted, count stays 65536.
REQ-038 Reset asserted with 3 pixels buffered -> all outputs zero asynchronously; after release, no oWren without new writes.
